// File: rtl/path_count_engine.sv
// Counts distinct paths from a source node to a sink node in a DAG. Nodes are
// expanded from a work queue in FIFO order, with a count per queued node.
// Adjacency lookups go to an external memory with a fixed one-cycle latency.
module path_count_engine #(
  parameter int unsigned PARAM_NODE_IDX_WIDTH  = 10,
  parameter int unsigned PARAM_EDGE_IDX_WIDTH  = 5,
  parameter int unsigned PARAM_ACCUM_VAL_WIDTH = 48,
  parameter int unsigned PARAM_FIFO_DEPTH      = 32
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             start,
  input  logic [PARAM_NODE_IDX_WIDTH-1:0]  start_node_idx,
  input  logic [PARAM_NODE_IDX_WIDTH-1:0]  end_node_idx,
  output logic                             adj_rd_en,
  output logic [PARAM_NODE_IDX_WIDTH-1:0]  adj_node_idx,
  output logic [PARAM_EDGE_IDX_WIDTH-1:0]  adj_edge_idx,
  input  logic [PARAM_NODE_IDX_WIDTH-1:0]  adj_next_idx,
  input  logic [PARAM_EDGE_IDX_WIDTH-1:0]  adj_edge_count,
  output logic                             busy,
  output logic                             done,
  output logic [PARAM_ACCUM_VAL_WIDTH-1:0] result,
  output logic                             saturated,
  output logic                             fifo_overflow
);

  localparam int unsigned NW    = PARAM_NODE_IDX_WIDTH;
  localparam int unsigned EW    = PARAM_EDGE_IDX_WIDTH;
  localparam int unsigned AW    = PARAM_ACCUM_VAL_WIDTH;
  localparam int unsigned DEPTH = PARAM_FIFO_DEPTH;
  localparam int unsigned PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_INIT, S_POP, S_WAIT, S_PROC, S_DONE
  } state_t;

  state_t state_q, state_d;

  logic [NW-1:0] start_lat, end_lat;
  logic [AW-1:0] cur_cnt;
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic          q_valid [DEPTH];
  logic [NW-1:0] q_idx   [DEPTH];
  logic [AW-1:0] q_cnt   [DEPTH];

  logic          q_empty, q_full;
  logic          match_hit;
  logic [PW-1:0] match_slot;
  logic [EW:0]   nxt_edge_w;
  logic          more_edges;
  logic [AW:0]   res_sum, mrg_sum;
  logic [AW-1:0] res_new, mrg_new;
  logic          res_clip, mrg_clip;

  logic          do_clear, do_init_hit, do_pop, do_acc, do_merge;
  logic          want_push, push_ok, push_ovf;
  logic [NW-1:0] push_idx;
  logic [AW-1:0] push_cnt;
  logic          rd_issue;
  logic [EW-1:0] rd_edge;

  // Queue status and same-cycle presence search (lowest matching slot wins)
  always_comb begin
    q_empty    = (rd_ptr == wr_ptr) && !q_valid[wr_ptr];
    q_full     = (rd_ptr == wr_ptr) &&  q_valid[wr_ptr];
    match_hit  = 1'b0;
    match_slot = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (!match_hit && q_valid[i] && (q_idx[i] == adj_next_idx)) begin
        match_hit  = 1'b1;
        match_slot = PW'(i);
      end
    end
  end

  // Saturating adders for the result and for a merged queue entry
  always_comb begin
    res_sum    = {1'b0, result} + {1'b0, cur_cnt};
    mrg_sum    = {1'b0, q_cnt[match_slot]} + {1'b0, cur_cnt};
    res_clip   = res_sum[AW];
    mrg_clip   = mrg_sum[AW];
    res_new    = res_clip ? {AW{1'b1}} : res_sum[AW-1:0];
    mrg_new    = mrg_clip ? {AW{1'b1}} : mrg_sum[AW-1:0];
    nxt_edge_w = {1'b0, adj_edge_idx} + (EW+1)'(1);
    more_edges = nxt_edge_w < {1'b0, adj_edge_count};
  end

  // Next-state and per-cycle action decode
  always_comb begin
    state_d     = state_q;
    do_clear    = 1'b0;
    do_init_hit = 1'b0;
    do_pop      = 1'b0;
    do_acc      = 1'b0;
    do_merge    = 1'b0;
    want_push   = 1'b0;
    push_idx    = start_lat;
    push_cnt    = AW'(1);
    rd_issue    = 1'b0;
    rd_edge     = '0;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          do_clear = 1'b1;
          state_d  = S_INIT;
        end
      end
      S_INIT: begin
        if (start_lat == end_lat) begin
          do_init_hit = 1'b1;
          state_d     = S_DONE;
        end else begin
          want_push = 1'b1;
          state_d   = S_POP;
        end
      end
      S_POP: begin
        if (q_empty) begin
          state_d = S_DONE;
        end else begin
          do_pop   = 1'b1;
          rd_issue = 1'b1;
          state_d  = S_WAIT;
        end
      end
      S_WAIT: state_d = S_PROC;
      S_PROC: begin
        if (adj_edge_count == '0) begin
          state_d = S_POP;
        end else begin
          if (adj_next_idx == end_lat) begin
            do_acc = 1'b1;
          end else if (match_hit) begin
            do_merge = 1'b1;
          end else begin
            want_push = 1'b1;
            push_idx  = adj_next_idx;
            push_cnt  = cur_cnt;
          end
          if (more_edges) begin
            rd_issue = 1'b1;
            rd_edge  = nxt_edge_w[EW-1:0];
            state_d  = S_WAIT;
          end else begin
            state_d = S_POP;
          end
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    push_ok  = want_push && !q_full;
    push_ovf = want_push &&  q_full;
    // A dropped push ends the run immediately
    if (push_ovf) begin
      rd_issue = 1'b0;
      state_d  = S_DONE;
    end
  end

  // State, outputs and work queue registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      busy          <= 1'b0;
      done          <= 1'b0;
      adj_rd_en     <= 1'b0;
      adj_node_idx  <= '0;
      adj_edge_idx  <= '0;
      result        <= '0;
      saturated     <= 1'b0;
      fifo_overflow <= 1'b0;
      start_lat     <= '0;
      end_lat       <= '0;
      cur_cnt       <= '0;
      rd_ptr        <= '0;
      wr_ptr        <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        q_valid[i] <= 1'b0;
        q_idx[i]   <= '0;
        q_cnt[i]   <= '0;
      end
    end else begin
      state_q   <= state_d;
      busy      <= (state_d != S_IDLE);
      done      <= (state_d == S_DONE);
      adj_rd_en <= rd_issue;
      if (rd_issue) begin
        adj_edge_idx <= rd_edge;
      end
      if (do_clear) begin
        start_lat     <= start_node_idx;
        end_lat       <= end_node_idx;
        result        <= '0;
        saturated     <= 1'b0;
        fifo_overflow <= 1'b0;
        rd_ptr        <= '0;
        wr_ptr        <= '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
          q_valid[i] <= 1'b0;
        end
      end
      if (do_init_hit) begin
        result <= AW'(1);
      end
      if (do_pop) begin
        adj_node_idx    <= q_idx[rd_ptr];
        cur_cnt         <= q_cnt[rd_ptr];
        q_valid[rd_ptr] <= 1'b0;
        rd_ptr          <= rd_ptr + PW'(1);
      end
      if (do_acc) begin
        result <= res_new;
        if (res_clip) saturated <= 1'b1;
      end
      if (do_merge) begin
        q_cnt[match_slot] <= mrg_new;
        if (mrg_clip) saturated <= 1'b1;
      end
      if (push_ok) begin
        q_valid[wr_ptr] <= 1'b1;
        q_idx[wr_ptr]   <= push_idx;
        q_cnt[wr_ptr]   <= push_cnt;
        wr_ptr          <= wr_ptr + PW'(1);
      end
      if (push_ovf) begin
        fifo_overflow <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_path_count_engine.sv
// Directed bench for path_count_engine: three instances (default, narrow
// accumulator, two-entry queue) sharing one graph table and start indices.
module tb_path_count_engine;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [9:0] s_node, e_node;
  logic [2:0] start_v;

  // Instance a: default parameters
  logic       a_rd, a_busy, a_done, a_sat, a_ovf;
  logic [9:0] a_node;
  logic [4:0] a_edge;
  logic [9:0] a_next = '0;
  logic [4:0] a_cnt  = '0;
  logic [47:0] a_res;
  // Instance b: 4-bit accumulator
  logic       b_rd, b_busy, b_done, b_sat, b_ovf;
  logic [9:0] b_node;
  logic [4:0] b_edge;
  logic [9:0] b_next = '0;
  logic [4:0] b_cnt  = '0;
  logic [3:0] b_res;
  // Instance c: two-entry queue
  logic       c_rd, c_busy, c_done, c_sat, c_ovf;
  logic [9:0] c_node;
  logic [4:0] c_edge;
  logic [9:0] c_next = '0;
  logic [4:0] c_cnt  = '0;
  logic [47:0] c_res;

  logic [4:0] g_deg [0:1023];
  logic [9:0] g_nxt [0:1023][0:7];

  int checks = 0;
  int failures = 0;
  int a_done_n = 0, b_done_n = 0, c_done_n = 0;
  int a_rd_n = 0, a_bad_edge_n = 0;

  always #5 clk = ~clk;

  path_count_engine u_a (
    .clk(clk), .rst_n(rst_n), .start(start_v[0]),
    .start_node_idx(s_node), .end_node_idx(e_node),
    .adj_rd_en(a_rd), .adj_node_idx(a_node), .adj_edge_idx(a_edge),
    .adj_next_idx(a_next), .adj_edge_count(a_cnt),
    .busy(a_busy), .done(a_done), .result(a_res),
    .saturated(a_sat), .fifo_overflow(a_ovf)
  );

  path_count_engine #(.PARAM_ACCUM_VAL_WIDTH(4)) u_b (
    .clk(clk), .rst_n(rst_n), .start(start_v[1]),
    .start_node_idx(s_node), .end_node_idx(e_node),
    .adj_rd_en(b_rd), .adj_node_idx(b_node), .adj_edge_idx(b_edge),
    .adj_next_idx(b_next), .adj_edge_count(b_cnt),
    .busy(b_busy), .done(b_done), .result(b_res),
    .saturated(b_sat), .fifo_overflow(b_ovf)
  );

  path_count_engine #(.PARAM_FIFO_DEPTH(2)) u_c (
    .clk(clk), .rst_n(rst_n), .start(start_v[2]),
    .start_node_idx(s_node), .end_node_idx(e_node),
    .adj_rd_en(c_rd), .adj_node_idx(c_node), .adj_edge_idx(c_edge),
    .adj_next_idx(c_next), .adj_edge_count(c_cnt),
    .busy(c_busy), .done(c_done), .result(c_res),
    .saturated(c_sat), .fifo_overflow(c_ovf)
  );

  // One-cycle-latency adjacency memories
  always @(posedge clk) begin
    if (a_rd) begin a_next <= g_nxt[a_node][a_edge[2:0]]; a_cnt <= g_deg[a_node]; end
    if (b_rd) begin b_next <= g_nxt[b_node][b_edge[2:0]]; b_cnt <= g_deg[b_node]; end
    if (c_rd) begin c_next <= g_nxt[c_node][c_edge[2:0]]; c_cnt <= g_deg[c_node]; end
  end

  // Event monitors
  always @(negedge clk) begin
    if (a_done) a_done_n++;
    if (b_done) b_done_n++;
    if (c_done) c_done_n++;
    if (a_rd) begin
      a_rd_n++;
      if (a_edge != 5'd0) a_bad_edge_n++;
    end
  end

  task automatic chk_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic clear_graph();
    for (int n = 0; n < 1024; n++) g_deg[n] = 5'd0;
  endtask

  task automatic add_edge(input int n, input int s);
    g_nxt[n][g_deg[n][2:0]] = 10'(s);
    g_deg[n] = g_deg[n] + 5'd1;
  endtask

  // Pulse start on instance d and wait (bounded) for its done pulse
  task automatic run(input int d, input int s, input int e, output int cyc);
    logic dn;
    bit ok;
    ok = 1'b0;
    cyc = 0;
    @(negedge clk);
    s_node = 10'(s);
    e_node = 10'(e);
    start_v[d] = 1'b1;
    for (int k = 0; k < 3000; k++) begin
      @(negedge clk);
      start_v = '0;
      cyc++;
      dn = (d == 0) ? a_done : (d == 1) ? b_done : c_done;
      if (dn) begin ok = 1'b1; break; end
    end
    chk_val("done_seen", 64'(ok), 64'd1);
  endtask

  initial begin
    int cyc, dn0, rd0, bad0;
    bit seen;
    rst_n   = 1'b0;
    start_v = '0;
    s_node  = '0;
    e_node  = '0;
    clear_graph();
    repeat (3) @(negedge clk);
    chk_val("reset_a", {a_rd, a_node, a_edge, a_busy, a_done, a_res, a_sat, a_ovf}, 64'd0);
    chk_val("reset_c", {c_rd, c_busy, c_done, c_res, c_sat, c_ovf}, 64'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Chain 0->1->2
    clear_graph(); add_edge(0, 1); add_edge(1, 2);
    dn0 = a_done_n;
    run(0, 0, 2, cyc);
    repeat (3) @(negedge clk);
    chk_val("chain_result", a_res, 64'd1);
    chk_val("chain_sat_ovf", {a_sat, a_ovf}, 64'd0);
    chk_val("chain_done_once", 64'(a_done_n - dn0), 64'd1);
    chk_val("chain_idle_busy", 64'(a_busy), 64'd0);

    // Diamond with merge into node 3
    clear_graph(); add_edge(0, 1); add_edge(0, 2); add_edge(1, 3); add_edge(2, 3); add_edge(3, 4);
    run(0, 0, 4, cyc);
    chk_val("merge_result", a_res, 64'd2);
    chk_val("merge_flags", {a_sat, a_ovf}, 64'd0);

    // start == end
    rd0 = a_rd_n;
    run(0, 5, 5, cyc);
    chk_val("same_latency", 64'(cyc), 64'd2);
    chk_val("same_result", a_res, 64'd1);
    chk_val("same_no_rd", 64'(a_rd_n - rd0), 64'd0);

    // Source with no out-edges
    clear_graph();
    rd0 = a_rd_n; bad0 = a_bad_edge_n;
    run(0, 7, 8, cyc);
    chk_val("deg0_result", a_res, 64'd0);
    chk_val("deg0_rd_count", 64'(a_rd_n - rd0), 64'd1);
    chk_val("deg0_edge_idx", 64'(a_bad_edge_n - bad0), 64'd0);

    // Layered graph with 20 paths on a 4-bit accumulator
    clear_graph();
    for (int m = 1; m <= 5; m++) begin
      add_edge(0, m);
      for (int k = 6; k <= 9; k++) add_edge(m, k);
    end
    for (int k = 6; k <= 9; k++) add_edge(k, 10);
    run(1, 0, 10, cyc);
    chk_val("sat_result", 64'(b_res), 64'd15);
    chk_val("sat_flag", 64'(b_sat), 64'd1);
    chk_val("sat_no_ovf", 64'(b_ovf), 64'd0);

    // Queue overflow on the two-entry instance
    clear_graph(); add_edge(0, 1); add_edge(0, 2); add_edge(0, 3);
    dn0 = c_done_n;
    run(2, 0, 9, cyc);
    repeat (2) @(negedge clk);
    chk_val("ovf_flag", 64'(c_ovf), 64'd1);
    chk_val("ovf_done_once", 64'(c_done_n - dn0), 64'd1);
    chk_val("ovf_result", c_res, 64'd0);

    // Reset asserted during WAIT
    clear_graph(); add_edge(0, 1); add_edge(1, 2);
    dn0 = a_done_n;
    seen = 1'b0;
    @(negedge clk);
    s_node = 10'd0; e_node = 10'd2; start_v[0] = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      start_v = '0;
      if (a_rd) begin seen = 1'b1; break; end
    end
    chk_val("rst_reached_wait", 64'(seen), 64'd1);
    rst_n = 1'b0;
    #1;
    chk_val("rst_outputs", {a_rd, a_node, a_edge, a_busy, a_done, a_res, a_sat, a_ovf}, 64'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk_val("rst_no_done", 64'(a_done_n - dn0), 64'd0);
    run(0, 0, 2, cyc);
    chk_val("rst_rerun_result", a_res, 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/path_count_engine.md
PATH_COUNT_ENGINE -- requirements
Module: path_count_engine

Interface
REQ-001 Parameters (name, default, meaning) SHALL be:
- PARAM_NODE_IDX_WIDTH, 10, node index width.
- PARAM_EDGE_IDX_WIDTH, 5, edge index/count width.
- PARAM_ACCUM_VAL_WIDTH, 48, path-count width.
- PARAM_FIFO_DEPTH, 32, work-queue entries; must be a power of 2 and at least 2.
REQ-002 Ports (name, direction, width, meaning) SHALL be:
- clk, in, 1, the single clock.
- rst_n, in, 1, reset, asynchronous, active-low.
- start, in, 1, start pulse.
- start_node_idx, in, NODE, source node.
- end_node_idx, in, NODE, sink node.
- adj_rd_en, out, 1, adjacency read strobe.
- adj_node_idx, out, NODE, node being expanded.
- adj_edge_idx, out, EDGE, edge ordinal requested.
- adj_next_idx, in, NODE, successor for the requested edge.
- adj_edge_count, in, EDGE, out-degree of adj_node_idx.
- busy, out, 1, run in progress.
- done, out, 1, one-cycle completion pulse.
- result, out, ACCUM, path count.
- saturated, out, 1, a path count clipped at its maximum.
- fifo_overflow, out, 1, push attempted while the queue was full.

Function
REQ-003 Adjacency memory latency SHALL be exactly 1 cycle: adj_next_idx and adj_edge_count are valid in the cycle after adj_rd_en=1.
REQ-004 States SHALL be IDLE, INIT, POP, WAIT, PROC and DONE.
REQ-005 IDLE: start=1 SHALL latch both node indices, clear result, saturated and fifo_overflow, and go to INIT; start is ignored in every other state.
REQ-006 INIT:
- If start==end, set result=1 and go to DONE.
- Otherwise push (start_node_idx, 1) and go to POP.
REQ-007 POP:
- Queue empty: go to DONE.
- Otherwise pop the head, clear its valid bit, hold its count as cur_cnt, drive adj_rd_en=1, adj_node_idx=head index, adj_edge_idx=0, and go to WAIT.
REQ-008 WAIT SHALL go to PROC; adj_node_idx and adj_edge_idx SHALL stay registered and unchanged.
REQ-009 PROC with adj_edge_count=0 SHALL do no accumulation and go to POP.
REQ-010 PROC otherwise SHALL handle successor s=adj_next_idx with exactly one of the following:
- s==end: result += cur_cnt.
- s matches a valid queue entry: that entry's count += cur_cnt (direct write; pointers unchanged).
- Neither: push (s, cur_cnt).
REQ-011 PROC next state: if adj_edge_idx+1 < adj_edge_count, issue adj_rd_en=1 with adj_edge_idx+1 and go to WAIT; otherwise go to POP.
REQ-012 The presence search SHALL compare s against all valid entries in the same cycle; on multiple matches the lowest slot wins.
REQ-013 All additions SHALL be unsigned at ACCUM width and saturate at 2^ACCUM-1. Any clip SHALL set saturated, which holds until the next start.
REQ-014 A push while the queue is full SHALL be dropped, set fifo_overflow and go to DONE; queue contents are left unchanged.
REQ-015 Read and write pointers SHALL wrap modulo PARAM_FIFO_DEPTH. Full means pointers equal and the slot at wr_ptr valid; empty means pointers equal and the slot invalid.
REQ-016 DONE SHALL pulse done=1 for one cycle and go to IDLE.
REQ-017 busy SHALL be 1 in every state except IDLE.
REQ-018 result, saturated and fifo_overflow SHALL hold their values from DONE until the next accepted start.
REQ-019 adj_rd_en SHALL be high only in the cycles given by REQ-007 and REQ-011.

Reset
REQ-020 rst_n=0 SHALL asynchronously force:
- state IDLE.
- all outputs 0.
- all queue valid bits, counts, indices and pointers 0.
REQ-021 Reset asserted mid-run SHALL abort the run without a done pulse; the first start after release SHALL begin a clean run.

Verification
REQ-022 The bench SHALL cover these directed scenarios:
- Chain 0->1->2, start=0, end=2: done once, result=1, saturated=0, fifo_overflow=0.
- Graph 0->{1,2}, 1->3, 2->3, 3->4, end=4: node 3 merged once (direct write, queue peak 2), result=2.
- start=end=5: done 2 cycles after start, result=1, adj_rd_en never asserted.
- Start node with out-degree 0: result=0; exactly one adj_rd_en with adj_edge_idx=0.
- ACCUM=4, layered graph with 20 paths to end: result=15, saturated=1.
- FIFO_DEPTH=2, node 0->{1,2,3}, end=9: fifo_overflow=1, done pulses. Separately, rst_n low during WAIT: outputs 0, no done, and the next start completes the chain case with result=1.
